dmem_arbiter: RTL

//  Shares the single data RAM port between two masters: M0 = CPU data port, M1 = UART boot loader / DMA.

---
 rtl/dmem_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dmem_arbiter                                               |
// | Description : Two-master data RAM port arbiter. M0 (CPU) has fixed       |
// |               priority; a saturating starvation counter forces M1 through|
// |               after STARVE_LIMIT consecutive losing cycles. One access   |
// |               per cycle, read data returned registered one cycle later.  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module dmem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [2:0]    m0_size,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic [2:0]    m1_size,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  output logic          ram_re,
  output logic [2:0]    ram_size,
  input  logic [DW-1:0] ram_rdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] C_LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_M0   = 2'd1,
    ST_M1   = 2'd2
  } state_t;

  state_t        state;       // owner of the current cycle
  state_t        r_state;     // owner of the previous cycle
  logic          r_rd;        // previous cycle issued a read
  logic [CW-1:0] r_starve_cnt;
  logic          w_force1;

  // Ownership decision and RAM port mux; reset blocks every access.
  always_comb begin
    w_force1  = (r_starve_cnt == C_LIMIT);
    state     = ST_IDLE;
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_size  = '0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    if (!rst) begin
      if (m0_req && !w_force1) begin
        state = ST_M0;
      end else if (m1_req && (!m0_req || w_force1)) begin
        state = ST_M1;
      end
    end
    case (state)
      ST_M0: begin
        m0_gnt    = 1'b1;
        ram_addr  = m0_addr;
        ram_wdata = m0_wdata;
        ram_size  = m0_size;
        ram_we    = m0_we;
        ram_re    = !m0_we;
      end
      ST_M1: begin
        m1_gnt    = 1'b1;
        ram_addr  = m1_addr;
        ram_wdata = m1_wdata;
        ram_size  = m1_size;
        ram_we    = m1_we;
        ram_re    = !m1_we;
      end
      default: ;
    endcase
  end

  // Read-valid follows the previous cycle's read grant; reset cancels it at once.
  always_comb begin
    m0_rvalid = r_rd && (r_state == ST_M0) && !rst;
    m1_rvalid = r_rd && (r_state == ST_M1) && !rst;
  end

  // Owner history, read-return capture and starvation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_rd         <= 1'b0;
      r_starve_cnt <= '0;
      m0_rdata     <= '0;
      m1_rdata     <= '0;
    end else begin
      r_state <= state;
      r_rd    <= ram_re;
      if (state == ST_M0 && !m0_we) begin
        m0_rdata <= ram_rdata;
      end
      if (state == ST_M1 && !m1_we) begin
        m1_rdata <= ram_rdata;
      end
      if (!m1_req || m1_gnt) begin
        r_starve_cnt <= '0;
      end else if (m0_gnt && (r_starve_cnt != C_LIMIT)) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
